// File: rtl/enable_period_meter_pkg.sv
// Shared definitions for the enable-strobe period meter: FSM state encoding
// and the width of the consecutive-match counter.
package enable_period_meter_pkg;

   localparam int MATCH_WIDTH = 4;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      MEASURE = 2'd1,
      LOCKED  = 2'd2
   } meter_state_t;

endpackage

// File: rtl/enable_period_meter_sat_counter.sv
// Saturating up-counter with synchronous clear, load-to-1 and a terminal-count flag.
// Clear has priority over load, and load has priority over increment.
module sat_counter #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clr,
   input  logic             load,
   input  logic             inc,
   output logic [WIDTH-1:0] q,
   output logic             tc
);

   localparam logic [WIDTH-1:0] ONES = '1;

   logic [WIDTH-1:0] count_reg;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count_reg <= '0;
      end else if (clr) begin
         count_reg <= '0;
      end else if (load) begin
         count_reg <= WIDTH'(1);
      end else if (inc && (count_reg != ONES)) begin
         count_reg <= count_reg + 1'b1;
      end
   end

   assign q  = count_reg;
   assign tc = (count_reg == ONES);

endmodule

// File: rtl/enable_period_meter.sv
// Measures the clock count between one-cycle enable strobes, locks after
// LOCK_COUNT identical periods, and flags deviations and strobe loss.
module enable_period_meter
   import enable_period_meter_pkg::*;
#(
   parameter int CNT_WIDTH  = 8,
   parameter int LOCK_COUNT = 4
) (
   input  logic                 clk,
   input  logic                 i_rst,
   input  logic                 i_sclr,
   input  logic                 i_en,
   output logic [CNT_WIDTH-1:0] o_period,
   output logic                 o_valid,
   output logic                 o_locked,
   output logic                 o_err,
   output logic                 o_ovf
);

   localparam logic [MATCH_WIDTH-1:0] LOCK_TARGET   = MATCH_WIDTH'(LOCK_COUNT);
   localparam bit                     LOCK_ON_FIRST = (LOCK_COUNT == 1);

   meter_state_t           state_reg;
   logic [MATCH_WIDTH-1:0] match_reg;
   logic [CNT_WIDTH-1:0]   period_reg;
   logic                   valid_reg;
   logic                   locked_reg;
   logic                   err_reg;
   logic                   ovf_reg;

   logic [CNT_WIDTH-1:0]   cnt;
   logic                   cnt_tc;
   logic                   cnt_clr;
   logic                   cnt_load;
   logic                   cnt_inc;
   logic                   timeout;
   logic                   same_period;
   logic [MATCH_WIDTH-1:0] match_inc;

   // A strobe on the all-ones edge is a real period, so timeout requires i_en low.
   assign timeout     = (state_reg != IDLE) && !i_en && cnt_tc;
   assign cnt_clr     = i_sclr || timeout;
   assign cnt_load    = i_en;
   assign cnt_inc     = (state_reg != IDLE);
   assign same_period = (cnt == period_reg);
   assign match_inc   = match_reg + 1'b1;

   sat_counter #(
      .WIDTH (CNT_WIDTH)
   ) u_cnt (
      .clk  (clk),
      .rst  (i_rst),
      .clr  (cnt_clr),
      .load (cnt_load),
      .inc  (cnt_inc),
      .q    (cnt),
      .tc   (cnt_tc)
   );

   always_ff @(posedge clk or posedge i_rst) begin
      if (i_rst) begin
         state_reg  <= IDLE;
         match_reg  <= '0;
         period_reg <= '0;
         valid_reg  <= 1'b0;
         locked_reg <= 1'b0;
         err_reg    <= 1'b0;
         ovf_reg    <= 1'b0;
      end else begin
         valid_reg <= 1'b0;
         err_reg   <= 1'b0;
         ovf_reg   <= 1'b0;
         if (i_sclr) begin
            state_reg  <= IDLE;
            match_reg  <= '0;
            period_reg <= '0;
            locked_reg <= 1'b0;
         end else if (timeout) begin
            state_reg  <= IDLE;
            match_reg  <= '0;
            period_reg <= '0;
            locked_reg <= 1'b0;
            ovf_reg    <= 1'b1;
         end else begin
            case (state_reg)
               IDLE: begin
                  if (i_en) begin
                     state_reg <= MEASURE;
                  end
               end
               MEASURE: begin
                  if (i_en) begin
                     valid_reg <= 1'b1;
                     if (same_period && (match_reg != '0)) begin
                        match_reg <= match_inc;
                        if (match_inc == LOCK_TARGET) begin
                           state_reg  <= LOCKED;
                           locked_reg <= 1'b1;
                        end
                     end else begin
                        period_reg <= cnt;
                        match_reg  <= MATCH_WIDTH'(1);
                        if (LOCK_ON_FIRST) begin
                           state_reg  <= LOCKED;
                           locked_reg <= 1'b1;
                        end
                     end
                  end
               end
               LOCKED: begin
                  // match stays saturated while periods keep agreeing
                  if (i_en) begin
                     valid_reg <= 1'b1;
                     if (!same_period) begin
                        period_reg <= cnt;
                        match_reg  <= MATCH_WIDTH'(1);
                        err_reg    <= 1'b1;
                        if (!LOCK_ON_FIRST) begin
                           state_reg  <= MEASURE;
                           locked_reg <= 1'b0;
                        end
                     end
                  end
               end
               default: begin
                  state_reg <= IDLE;
               end
            endcase
         end
      end
   end

   assign o_period = period_reg;
   assign o_valid  = valid_reg;
   assign o_locked = locked_reg;
   assign o_err    = err_reg;
   assign o_ovf    = ovf_reg;

endmodule

// File: tb/tb_enable_period_meter.sv
// Self-checking bench: two meters (LOCK_COUNT 4 and 1) share one stimulus and are
// compared every cycle against a timestamp-based model of the measurement rules.
module tb_enable_period_meter;

   localparam int CW   = 8;
   localparam int MAXP = 255;

   logic clk    = 1'b0;
   logic i_rst  = 1'b1;
   logic i_sclr = 1'b0;
   logic i_en   = 1'b0;

   logic [CW-1:0] period_a, period_b;
   logic          valid_a, valid_b, locked_a, locked_b;
   logic          err_a, err_b, ovf_a, ovf_b;

   always #5 clk = ~clk;

   enable_period_meter #(.CNT_WIDTH(CW), .LOCK_COUNT(4)) dut_a (
      .clk      (clk),
      .i_rst    (i_rst),
      .i_sclr   (i_sclr),
      .i_en     (i_en),
      .o_period (period_a),
      .o_valid  (valid_a),
      .o_locked (locked_a),
      .o_err    (err_a),
      .o_ovf    (ovf_a)
   );

   enable_period_meter #(.CNT_WIDTH(CW), .LOCK_COUNT(1)) dut_b (
      .clk      (clk),
      .i_rst    (i_rst),
      .i_sclr   (i_sclr),
      .i_en     (i_en),
      .o_period (period_b),
      .o_valid  (valid_b),
      .o_locked (locked_b),
      .o_err    (err_b),
      .o_ovf    (ovf_b)
   );

   int pass_cnt  = 0;
   int total_cnt = 0;
   int now_t     = 0;

   // Model: time of last strobe, last period, length of the run of equal periods.
   bit m_armed  [2];
   int m_last   [2];
   int m_prd    [2];
   int m_run    [2];
   bit m_locked [2];
   bit e_valid  [2];
   bit e_err    [2];
   bit e_ovf    [2];
   int m_lc     [2] = '{4, 1};

   task automatic model_reset();
      for (int i = 0; i < 2; i++) begin
         m_armed[i]  = 1'b0;
         m_last[i]   = 0;
         m_prd[i]    = 0;
         m_run[i]    = 0;
         m_locked[i] = 1'b0;
         e_valid[i]  = 1'b0;
         e_err[i]    = 1'b0;
         e_ovf[i]    = 1'b0;
      end
   endtask

   task automatic model_step(input bit en, input bit sclr);
      for (int i = 0; i < 2; i++) begin
         int d;
         e_valid[i] = 1'b0;
         e_err[i]   = 1'b0;
         e_ovf[i]   = 1'b0;
         d = now_t - m_last[i];
         if (sclr) begin
            m_armed[i]  = 1'b0;
            m_prd[i]    = 0;
            m_run[i]    = 0;
            m_locked[i] = 1'b0;
         end else if (!m_armed[i]) begin
            if (en) begin
               m_armed[i] = 1'b1;
               m_last[i]  = now_t;
            end
         end else if (en) begin
            e_valid[i] = 1'b1;
            m_last[i]  = now_t;
            if (d == m_prd[i] && m_run[i] > 0) begin
               if (m_run[i] < m_lc[i]) m_run[i] = m_run[i] + 1;
            end else begin
               e_err[i] = m_locked[i];
               m_prd[i] = d;
               m_run[i] = 1;
            end
            m_locked[i] = (m_run[i] >= m_lc[i]);
         end else if (d == MAXP) begin
            e_ovf[i]    = 1'b1;
            m_armed[i]  = 1'b0;
            m_prd[i]    = 0;
            m_run[i]    = 0;
            m_locked[i] = 1'b0;
         end
      end
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total_cnt++;
      assert (obs === exp) pass_cnt++;
      else $error("FAIL %s t=%0d observed=%0h expected=%0h", tag, now_t, obs, exp);
   endtask

   task automatic check_all();
      chk("a.period", 32'(period_a), 32'(m_prd[0]));
      chk("a.valid",  32'(valid_a),  32'(e_valid[0]));
      chk("a.locked", 32'(locked_a), 32'(m_locked[0]));
      chk("a.err",    32'(err_a),    32'(e_err[0]));
      chk("a.ovf",    32'(ovf_a),    32'(e_ovf[0]));
      chk("b.period", 32'(period_b), 32'(m_prd[1]));
      chk("b.valid",  32'(valid_b),  32'(e_valid[1]));
      chk("b.locked", 32'(locked_b), 32'(m_locked[1]));
      chk("b.err",    32'(err_b),    32'(e_err[1]));
      chk("b.ovf",    32'(ovf_b),    32'(e_ovf[1]));
   endtask

   task automatic tick(input bit en, input bit sclr);
      i_en   = en;
      i_sclr = sclr;
      @(posedge clk);
      model_step(en, sclr);
      now_t++;
      #1;
      check_all();
   endtask

   // Strobe groups: each strobe arrives exactly p cycles after the previous one.
   task automatic gaps(input int p, input int n);
      repeat (n) begin
         repeat (p - 1) tick(1'b0, 1'b0);
         tick(1'b1, 1'b0);
      end
   endtask

   // Called just after a rising edge: reset pulses between edges.
   task automatic async_reset();
      #2;
      i_rst = 1'b1;
      #1;
      model_reset();
      check_all();
      #1;
      i_rst = 1'b0;
   endtask

   initial begin
      model_reset();
      repeat (3) @(posedge clk);
      #1;
      check_all();
      i_rst = 1'b0;

      // Lock at P=8, deviate to P=6, re-lock at P=6.
      tick(1'b1, 1'b0);
      gaps(8, 4);
      gaps(8, 2);
      gaps(6, 1);
      gaps(6, 4);

      // Loss of strobe times out after 255 cycles.
      repeat (MAXP) tick(1'b0, 1'b0);
      repeat (3) tick(1'b0, 1'b0);

      // A strobe on the all-ones edge is a valid period.
      tick(1'b1, 1'b0);
      gaps(8, 5);
      gaps(MAXP, 1);
      gaps(MAXP - 1, 1);

      // Constant enable: P=1.
      repeat (8) tick(1'b1, 1'b0);

      // Asynchronous reset mid-period while locked.
      tick(1'b0, 1'b0);
      gaps(8, 6);
      repeat (3) tick(1'b0, 1'b0);
      async_reset();
      gaps(8, 6);

      // Synchronous clear coincident with a strobe.
      tick(1'b1, 1'b1);
      repeat (3) tick(1'b0, 1'b0);
      tick(1'b1, 1'b0);
      gaps(5, 5);

      // Randomized segments.
      for (int s = 0; s < 60; s++) begin
         int mode;
         mode = $urandom_range(0, 5);
         case (mode)
            0: gaps($urandom_range(1, 12), $urandom_range(1, 8));
            1: gaps($urandom_range(MAXP - 2, MAXP), 1);
            2: repeat (MAXP + 1) tick(1'b0, 1'b0);
            3: tick(1'($urandom_range(0, 1)), 1'b1);
            4: async_reset();
            default: repeat (20) tick(1'($urandom_range(0, 9) < 3), 1'b0);
         endcase
      end

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
